// File: rtl/goldschmidt_pkg.sv
// goldschmidt_pkg
//   Shared definitions for the Goldschmidt iterative divider:
//   - gs_state_t    : controller state encoding
//   - DEFAULT_WIDTH : default operand/result width (Q1.(WIDTH-1))
//   - DEFAULT_ITERS : default number of refinement iterations after the seed
//   - k0_pattern()  : bit pattern of the seed factor 1.5 in Q1.(width-1)
package goldschmidt_pkg;

    localparam int DEFAULT_WIDTH = 28;
    localparam int DEFAULT_ITERS = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEED_N = 3'd1,
        SEED_D = 3'd2,
        ITER_N = 3'd3,
        ITER_D = 3'd4,
        DONE   = 3'd5
    } gs_state_t;

    // 1.5 in Q1.(width-1) is 2'b11 followed by zeros.
    function automatic logic [63:0] k0_pattern(input int width);
        return 64'(3) << (width - 2);
    endfunction

endpackage

// File: rtl/goldschmidt_mulstep.sv
// goldschmidt_mulstep
//   Combinational fixed-point multiply with rescale back to Q1.(WIDTH-1).
//   The full 2*WIDTH product is Q2.(2*WIDTH-2); keeping bits
//   [2*WIDTH-2 : WIDTH-1] drops the integer overflow bit and truncates the
//   low fraction bits (no rounding).
// Ports:
//   a, b : input  [WIDTH-1:0]  multiplicands, Q1.(WIDTH-1)
//   p    : output [WIDTH-1:0]  truncated product, Q1.(WIDTH-1)
module goldschmidt_mulstep #(
    parameter int WIDTH = 28
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] full;
    logic               unused_bits;

    assign full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign p    = full[2*WIDTH-2:WIDTH-1];

    // Discarded bits: the product's top bit and the truncated fraction.
    assign unused_bits = ^{full[2*WIDTH-1], full[WIDTH-2:0]};

endmodule

// File: rtl/goldschmidt_iter_div.sv
// goldschmidt_iter_div
//   Iterative Goldschmidt divider, quotient = numerator / denominator, all
//   values Q1.(WIDTH-1). One multiplier is time-shared: each refinement step
//   spends one cycle on n = n*k and one on d = d*k, k = 2 - d.
//
//   Handshakes (valid/ready): a transfer happens on a rising clk edge where
//   valid and ready are both 1. The producer holds valid and data stable
//   until that edge; ready may be given without waiting for valid.
//   Input side : in_valid/in_ready, in_ready = 1 only in IDLE.
//   Output side: out_valid/out_ready, quotient/err held stable in DONE.
//
// Ports:
//   clk         : input              clock, rising edge
//   reset       : input              asynchronous active-low reset
//   in_valid    : input              operands valid
//   in_ready    : output             operands accepted this cycle
//   numerator   : input  [WIDTH-1:0] dividend, legal range [0, 1.0)
//   denominator : input  [WIDTH-1:0] divisor, legal range [0.5, 1.0)
//   out_valid   : output             quotient/err valid
//   out_ready   : input              consumer takes the result
//   quotient    : output [WIDTH-1:0] result, all ones on illegal operands
//   err         : output             operands were out of range
//   dbg_state   : output gs_state_t  current controller state
module goldschmidt_iter_div
    import goldschmidt_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               ITERS = DEFAULT_ITERS,
    parameter logic [WIDTH-1:0] K0    = WIDTH'(k0_pattern(WIDTH))
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             err,
    output gs_state_t        dbg_state
);

    localparam int               CW        = $clog2(ITERS + 1);
    localparam logic [CW-1:0]    ITER_LAST = CW'(ITERS - 1);

    gs_state_t        state;
    gs_state_t        state_nxt;
    logic [CW-1:0]    iter_cnt;
    logic [WIDTH-1:0] num_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] quotient_q;
    logic             err_q;

    logic             accept;
    logic             operands_legal;
    logic             last_iter;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] mul_p;
    logic [WIDTH-1:0] k_nxt;

    assign accept         = in_valid && (state == IDLE);
    assign operands_legal = (denominator[WIDTH-1:WIDTH-2] == 2'b01) && !numerator[WIDTH-1];
    assign last_iter      = (iter_cnt == ITER_LAST);

    // k = 2 - d: 2.0 is 2^WIDTH in this format, so the WIDTH-bit two's
    // complement negation of the freshly computed d gives it directly.
    assign k_nxt = ~mul_p + WIDTH'(1);

    // Operand select for the shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SEED_N: begin mul_a = num_q; mul_b = K0;  end
            SEED_D: begin mul_a = den_q; mul_b = K0;  end
            ITER_N: begin mul_a = n_q;   mul_b = k_q; end
            ITER_D: begin mul_a = d_q;   mul_b = k_q; end
            default: ;
        endcase
    end

    goldschmidt_mulstep #(.WIDTH(WIDTH)) u_mulstep (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = operands_legal ? SEED_N : DONE;
            SEED_N:  state_nxt = SEED_D;
            SEED_D:  state_nxt = ITER_N;
            ITER_N:  state_nxt = ITER_D;
            ITER_D:  state_nxt = last_iter ? DONE : ITER_N;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt   <= '0;
            num_q      <= '0;
            den_q      <= '0;
            n_q        <= '0;
            d_q        <= '0;
            k_q        <= '0;
            quotient_q <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        num_q    <= numerator;
                        den_q    <= denominator;
                        iter_cnt <= '0;
                        if (!operands_legal) begin
                            quotient_q <= '1;
                            err_q      <= 1'b1;
                        end
                    end
                end
                SEED_N: n_q <= mul_p;
                SEED_D: begin
                    d_q <= mul_p;
                    k_q <= k_nxt;
                end
                ITER_N: n_q <= mul_p;
                ITER_D: begin
                    d_q      <= mul_p;
                    k_q      <= k_nxt;
                    iter_cnt <= iter_cnt + CW'(1);
                    // n was finalised by the preceding ITER_N step.
                    if (last_iter) begin
                        quotient_q <= n_q;
                        err_q      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign quotient  = quotient_q;
    assign err       = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_goldschmidt_iter_div.sv
// tb_goldschmidt_iter_div
//   Directed and randomized checks of goldschmidt_iter_div at WIDTH=28,
//   ITERS=5. Results are predicted by a reference model that evaluates the
//   Goldschmidt recurrence with plain integer arithmetic, and directed cases
//   are also compared against the exact quotient N/D.
module tb_goldschmidt_iter_div;
    import goldschmidt_pkg::*;

    localparam int W        = 28;
    localparam int IT       = 5;
    localparam int NUM_RAND = 150;
    localparam int LAT      = 2 * (IT + 1);

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     numerator;
    logic [W-1:0]     denominator;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     quotient;
    logic             err;
    gs_state_t        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W:0] exp_q[$];

    goldschmidt_iter_div #(.WIDTH(W), .ITERS(IT)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .numerator   (numerator),
        .denominator (denominator),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        n_fail = n_fail + 1;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return W'(p >> (W - 1));
    endfunction

    function automatic logic [W-1:0] two_minus(input logic [W-1:0] d);
        return W'((longint'(1) << W) - longint'(d));
    endfunction

    // Returns {err, quotient}.
    function automatic logic [W:0] ref_div(input logic [W-1:0] nn, input logic [W-1:0] dd);
        logic [W-1:0] k0;
        logic [W-1:0] n;
        logic [W-1:0] d;
        logic [W-1:0] k;
        longint       top;
        top = longint'(dd) >> (W - 2);
        if (top != 1 || (longint'(nn) >> (W - 1)) != 0)
            return {1'b1, {W{1'b1}}};
        k0 = W'(longint'(3) << (W - 2));
        n  = fx_mul(nn, k0);
        d  = fx_mul(dd, k0);
        k  = two_minus(d);
        for (int i = 0; i < IT; i++) begin
            n = fx_mul(n, k);
            d = fx_mul(d, k);
            k = two_minus(d);
        end
        return {1'b0, n};
    endfunction

    function automatic int exact_q(input logic [W-1:0] nn, input logic [W-1:0] dd);
        return int'((longint'(nn) << (W - 1)) / longint'(dd));
    endfunction

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // ---------------- driver tasks ----------------
    // Presents one operand pair, measures edges from the accepting edge to
    // out_valid, holds out_ready low for 'hold' cycles, then retires it.
    task automatic run_div(input logic [W-1:0] n, input logic [W-1:0] d, input int hold,
                           output logic [W-1:0] q, output logic e, output int lat);
        int w;
        @(negedge clk);
        numerator   = n;
        denominator = d;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_at_accept", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", 64'(out_valid), 64'(1));
        q = quotient;
        e = err;
        // Stall the consumer; new operands offered meanwhile must be ignored.
        for (int i = 0; i < hold; i++) begin
            numerator   = W'($urandom);
            denominator = W'($urandom);
            in_valid    = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("stall_quotient_stable", 64'(quotient), 64'(q));
            check("stall_err_stable", 64'(err), 64'(e));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_in_ready_low", 64'(in_ready), 64'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_handshake", 64'(in_ready), 64'(1));
        check("out_valid_after_handshake", 64'(out_valid), 64'(0));
    endtask

    task automatic directed(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                            input int hold, input int ideal);
        logic [W-1:0] q;
        logic         e;
        int           lat;
        logic [W:0]   r;
        r = ref_div(n, d);
        run_div(n, d, hold, q, e, lat);
        check({tag, "_quotient"}, 64'(q), 64'(r[W-1:0]));
        check({tag, "_err"}, 64'(e), 64'(r[W]));
        if (r[W]) begin
            // out_valid rises on the accepting edge: seen in the next cycle.
            check({tag, "_latency"}, 64'(lat), 64'(0));
        end else begin
            check({tag, "_latency"}, 64'(lat), 64'(LAT));
            check({tag, "_within_4lsb"}, 64'(abs_diff(int'(q), ideal) <= 4), 64'(1));
        end
    endtask

    // ---------------- main sequence ----------------
    logic [W-1:0] held_q;
    logic         held_e;
    logic         held;
    logic         fire_in;
    int           issued;
    int           retired;
    int           cyc;
    int           pulses;
    logic [W:0]   e_item;
    logic [W-1:0] rn;
    logic [W-1:0] rd;

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        numerator   = '0;
        denominator = '0;
        repeat (3) @(negedge clk);
        check("rst_out_valid_during", 64'(out_valid), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // Directed values.
        directed("half_over_3q", 28'h4000000, 28'h6000000, 5, 32'h5555555);
        directed("quarter_over_half", 28'h2000000, 28'h4000000, 0, 32'h4000000);
        directed("max_over_half", 28'h7FFFFFF, 28'h4000000, 0, 32'hFFFFFFE);
        directed("zero_num", 28'h0000000, 28'h5000000, 0, 0);
        directed("near_one", 28'h7FFFFFF, 28'h7FFFFFF, 0, exact_q(28'h7FFFFFF, 28'h7FFFFFF));
        directed("bad_den_zero", 28'h4000000, 28'h0000000, 0, 0);
        directed("bad_num_msb", 28'h8000000, 28'h6000000, 2, 0);
        directed("bad_den_high", 28'h1000000, 28'hC000000, 0, 0);

        // Reset during a divide.
        @(negedge clk);
        numerator   = 28'h3000000;
        denominator = 28'h5000000;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_quotient", 64'(quotient), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("postrst_in_ready", 64'(in_ready), 64'(1));
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("postrst_no_stale_valid", 64'(pulses), 64'(0));
        directed("after_reset", 28'h3000000, 28'h5000000, 0, exact_q(28'h3000000, 28'h5000000));

        // Randomized traffic with stalls on both sides.
        issued  = 0;
        retired = 0;
        cyc     = 0;
        held    = 1'b0;
        fire_in = 1'b0;
        while (retired < NUM_RAND && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (fire_in) in_valid = 1'b0;
            if (!in_valid && issued < NUM_RAND && $urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    rn = W'($urandom);
                    rd = W'($urandom);
                    if (rd[W-1:W-2] == 2'b01) rn[W-1] = 1'b1;
                end else begin
                    rn = W'($urandom_range(0, (1 << (W - 1)) - 1));
                    rd = W'((1 << (W - 2)) + $urandom_range(0, (1 << (W - 2)) - 1));
                end
                numerator   = rn;
                denominator = rd;
                in_valid    = 1'b1;
                exp_q.push_back(ref_div(rn, rd));
                issued++;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (held) begin
                check("rand_hold_valid", 64'(out_valid), 64'(1));
                check("rand_hold_quotient", 64'(quotient), 64'(held_q));
                check("rand_hold_err", 64'(err), 64'(held_e));
            end
            fire_in = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", 64'(1), 64'(0));
                end else begin
                    e_item = exp_q.pop_front();
                    check("rand_quotient", 64'(quotient), 64'(e_item[W-1:0]));
                    check("rand_err", 64'(err), 64'(e_item[W]));
                end
                retired++;
                held = 1'b0;
            end else if (out_valid) begin
                held   = 1'b1;
                held_q = quotient;
                held_e = err;
            end else begin
                held = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_all_retired", 64'(retired), 64'(NUM_RAND));
        check("rand_queue_empty", 64'(exp_q.size()), 64'(0));

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
